// File: rtl/uart_tx_ctrl_if.sv
// Signal bundle between the UART TX frame controller, its upstream source and the serializer.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, busy
  );

  modport slave (
    input  Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start/data/parity/stop sequencing beside the shift-register serializer.
// Optional macro UART_TX_TWO_STOP_EN adds a second stop bit.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP2  = 3'd5;
`endif

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_par_q;
  logic                  par_en_q;
  logic                  par_typ_q;

  assign p_data = bus.P_DATA;

  // The data parity and PAR_TYP are latched separately; their XOR is the frame's parity bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_par_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.Data_Valid) begin
        data_par_q <= ^p_data;
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.Data_Valid ? START : IDLE;
      START:   state_nxt = DATA;
      DATA: begin
        if (!bus.ser_done)  state_nxt = DATA;
        else if (par_en_q)  state_nxt = PARITY;
        else                state_nxt = STOP;
      end
      PARITY:  state_nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:    state_nxt = STOP2;
      STOP2:   state_nxt = IDLE;
`else
      STOP:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.TX_OUT = 1'b1;
    bus.ser_en = 1'b0;
    bus.busy   = 1'b0;
    case (state)
      START: begin
        bus.TX_OUT = 1'b0;
        bus.busy   = 1'b1;
      end
      DATA: begin
        bus.TX_OUT = bus.ser_data;
        bus.ser_en = 1'b1;
        bus.busy   = 1'b1;
      end
      PARITY: begin
        bus.TX_OUT = data_par_q ^ par_typ_q;
        bus.busy   = 1'b1;
      end
      STOP:    bus.busy = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      STOP2:   bus.busy = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural 8-bit serializer and a no-pulse-while-busy monitor.
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  int   viol;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Serializer model: reloads on every Data_Valid, shifts LSB first while enabled.
  logic [7:0] sreg;
  logic [2:0] cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (bus.Data_Valid) begin
      sreg <= bus.P_DATA;
      cnt  <= '0;
    end else if (bus.ser_en) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + 3'd1;
    end
  end
  assign bus.ser_data = sreg[0];
  assign bus.ser_done = (cnt == 3'd7);

  always @(posedge clk) begin
    if (reset_n && bus.Data_Valid && bus.busy) viol <= viol + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] with_stop(input logic [31:0] core);
    logic [31:0] ones;
    ones = (32'd1 << NSTOP) - 32'd1;
    return (core << NSTOP) | ones;
  endfunction

  // Call right after driving Data_Valid=1 at a negedge. Captures TX_OUT while busy, first bit in MSB.
  task automatic run_frame(input int pulse_at, output logic [31:0] bits, output int nbusy,
                           output int nen, output int lead);
    logic done;
    bits  = '0;
    nbusy = 0;
    nen   = 0;
    lead  = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus.Data_Valid = 1'b0;
      if (bus.busy) begin
        bits = {bits[30:0], bus.TX_OUT};
        nbusy++;
        if (bus.ser_en) nen++;
        if (nbusy == pulse_at) begin
          bus.Data_Valid = 1'b1;
          bus.PAR_TYP    = ~bus.PAR_TYP;
        end
      end else if (nbusy > 0) begin
        done = 1'b1;
      end else begin
        lead++;
      end
    end
    check("frame_end", {31'd0, done}, 32'd1);
  endtask

  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
  endtask

  logic [31:0] bits;
  int nbusy, nen, lead;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    viol     = 0;
    reset_n  = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx",   {31'd0, bus.TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, bus.busy},   32'd0);
    check("rst_en",   {31'd0, bus.ser_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 0xA5 even parity
    start(8'hA5, 1'b1, 1'b0);
    run_frame(0, bits, nbusy, nen, lead);
    check("a5_even_bits", bits, with_stop(32'b0_10100101_0));
    check("a5_even_len",  nbusy, 10 + NSTOP);
    check("a5_even_sen",  nen, 8);

    @(negedge clk);
    start(8'hA5, 1'b1, 1'b1);
    run_frame(0, bits, nbusy, nen, lead);
    check("a5_odd_bits", bits, with_stop(32'b0_10100101_1));
    check("a5_odd_len",  nbusy, 10 + NSTOP);

    @(negedge clk);
    start(8'h3C, 1'b0, 1'b0);
    run_frame(0, bits, nbusy, nen, lead);
    check("3c_nopar_bits", bits, with_stop(32'b0_00111100));
    check("3c_nopar_len",  nbusy, 9 + NSTOP);
    check("3c_nopar_sen",  nen, 8);

    // Back-to-back: second pulse in the first IDLE cycle after the stop bit
    @(negedge clk);
    start(8'h01, 1'b1, 1'b0);
    run_frame(0, bits, nbusy, nen, lead);
    check("b2b_f1_bits", bits, with_stop(32'b0_10000000_1));
    check("b2b_gap_tx",  {31'd0, bus.TX_OUT}, 32'd1);
    start(8'hFF, 1'b1, 1'b0);
    run_frame(0, bits, nbusy, nen, lead);
    check("b2b_lead",    lead, 0);
    check("b2b_f2_bits", bits, with_stop(32'b0_11111111_0));
    check("b2b_f2_len",  nbusy, 10 + NSTOP);
    check("no_pulse_while_busy", viol, 0);

    // Mid-frame pulse in DATA cycle 3 reloads the serializer; PAR_TYP flips but latched parity holds
    @(negedge clk);
    start(8'hA5, 1'b1, 1'b0);
    run_frame(4, bits, nbusy, nen, lead);
    check("mid_bits", bits, with_stop(32'b0_10110100101_0));
    check("mid_len",  nbusy, 13 + NSTOP);
    check("mid_sen",  nen, 11);
    check("mid_pulse_seen", viol, 1);

    // Asynchronous reset in the 4th DATA cycle
    @(negedge clk);
    bus.PAR_TYP = 1'b0;
    start(8'h55, 1'b1, 1'b0);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_en", {31'd0, bus.ser_en}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx",   {31'd0, bus.TX_OUT}, 32'd1);
    check("abort_busy", {31'd0, bus.busy},   32'd0);
    check("abort_en",   {31'd0, bus.ser_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_tx", {31'd0, bus.TX_OUT}, 32'd1);
    start(8'h55, 1'b1, 1'b0);
    run_frame(0, bits, nbusy, nen, lead);
    check("55_bits", bits, with_stop(32'b0_10101010_0));
    check("55_len",  nbusy, 10 + NSTOP);
    check("final_idle_tx", {31'd0, bus.TX_OUT}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
